// File: rtl/instr_mem_loader.sv
// ---------------------------------------------------------------------------
// instr_mem_loader
//   Boot-time program loader. Collects a byte stream over a valid/ready
//   handshake, packs four bytes (most significant first) into a 32-bit
//   instruction word and writes each word to the instruction memory write
//   port at consecutive byte addresses starting at 0. The CPU is held in
//   reset (cpu_hold_o) until the requested number of words has been written.
//   A running 32-bit sum of every written word is kept on chk_o.
// ---------------------------------------------------------------------------
module instr_mem_loader #(
   parameter int MEM_WORDS = 32,
   parameter int CW        = 6
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          start_i,
   input  logic [CW-1:0] len_i,
   input  logic          byte_valid_i,
   input  logic [7:0]    byte_data_i,
   output logic          byte_ready_o,
   output logic          mem_we_o,
   output logic [31:0]   mem_addr_o,
   output logic [31:0]   mem_data_o,
   output logic          cpu_hold_o,
   output logic          busy_o,
   output logic          done_o,
   output logic          err_o,
   output logic [31:0]   chk_o
);

   // ------------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------------
   localparam logic [CW-1:0] MAX_LEN = CW'(MEM_WORDS);
   localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
   localparam int            PAD_W   = 32 - CW - 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RECV  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   // ------------------------------------------------------------------------
   // Helper functions
   // ------------------------------------------------------------------------

   // A load length is usable only if it names at least one word and fits
   // inside the instruction memory.
   function automatic logic len_legal(input logic [CW-1:0] len);
      return (len != CNT_ZERO) && (len <= MAX_LEN);
   endfunction

   // Byte address of a word index, zero-extended to the 32-bit bus.
   function automatic logic [31:0] word_addr(input logic [CW-1:0] cnt);
      return {{PAD_W{1'b0}}, cnt, 2'b00};
   endfunction

   // Drop byte k of the word into its big-endian lane [31-8k -: 8].
   function automatic logic [31:0] insert_byte(input logic [31:0] word,
                                               input logic [1:0]  k,
                                               input logic [7:0]  b);
      logic [31:0] r;
      r = word;
      case (k)
         2'd0:    r[31:24] = b;
         2'd1:    r[23:16] = b;
         2'd2:    r[15:8]  = b;
         2'd3:    r[7:0]   = b;
         default: r        = word;
      endcase
      return r;
   endfunction

   // ------------------------------------------------------------------------
   // State and next-state
   // ------------------------------------------------------------------------
   state_t        state_q,      state_d;
   logic [CW-1:0] len_q,        len_d;
   logic [CW-1:0] word_cnt_q,   word_cnt_d;
   logic [1:0]    byte_cnt_q,   byte_cnt_d;
   logic [31:0]   word_q,       word_d;
   logic          byte_ready_q, byte_ready_d;
   logic          mem_we_q,     mem_we_d;
   logic [31:0]   mem_addr_q,   mem_addr_d;
   logic [31:0]   mem_data_q,   mem_data_d;
   logic          cpu_hold_q,   cpu_hold_d;
   logic          busy_q,       busy_d;
   logic          done_q,       done_d;
   logic          err_q,        err_d;
   logic [31:0]   chk_q,        chk_d;

   logic          accept_s;
   logic [31:0]   word_asm_s;
   logic [CW-1:0] word_cnt_inc_s;

   // A byte moves only when the loader has advertised ready in RECV.
   assign accept_s       = (state_q == RECV) && byte_valid_i && byte_ready_q;
   // Word as it looks once the byte on the bus is merged in.
   assign word_asm_s     = insert_byte(word_q, byte_cnt_q, byte_data_i);
   assign word_cnt_inc_s = word_cnt_q + CNT_ONE;

   // Next-state and next-output computation for the load sequencer.
   always_comb begin
      state_d      = state_q;
      len_d        = len_q;
      word_cnt_d   = word_cnt_q;
      byte_cnt_d   = byte_cnt_q;
      word_d       = word_q;
      byte_ready_d = byte_ready_q;
      mem_we_d     = 1'b0;
      mem_addr_d   = mem_addr_q;
      mem_data_d   = mem_data_q;
      cpu_hold_d   = cpu_hold_q;
      busy_d       = busy_q;
      done_d       = done_q;
      err_d        = err_q;
      chk_d        = chk_q;

      case (state_q)
         // IDLE and DONE react to start_i identically; only DONE releases
         // the CPU while waiting.
         IDLE, DONE: begin
            if (start_i) begin
               if (len_legal(len_i)) begin
                  state_d      = RECV;
                  len_d        = len_i;
                  word_cnt_d   = CNT_ZERO;
                  byte_cnt_d   = 2'd0;
                  word_d       = 32'h0000_0000;
                  chk_d        = 32'h0000_0000;
                  err_d        = 1'b0;
                  byte_ready_d = 1'b1;
                  busy_d       = 1'b1;
                  done_d       = 1'b0;
                  cpu_hold_d   = 1'b1;
               end else begin
                  state_d      = IDLE;
                  err_d        = 1'b1;
                  byte_ready_d = 1'b0;
                  busy_d       = 1'b0;
                  done_d       = 1'b0;
                  cpu_hold_d   = 1'b1;
               end
            end else begin
               state_d = state_q;
            end
         end

         // Gather bytes; the fourth byte launches the write strobe directly
         // so it appears on the very next cycle.
         RECV: begin
            if (accept_s) begin
               word_d = word_asm_s;
               if (byte_cnt_q == 2'd3) begin
                  state_d      = WRITE;
                  byte_cnt_d   = 2'd0;
                  byte_ready_d = 1'b0;
                  mem_we_d     = 1'b1;
                  mem_addr_d   = word_addr(word_cnt_q);
                  mem_data_d   = word_asm_s;
               end else begin
                  byte_cnt_d = byte_cnt_q + 2'd1;
               end
            end else begin
               state_d = RECV;
            end
         end

         // Single write cycle: fold the word into the checksum and decide
         // whether the program is complete.
         WRITE: begin
            chk_d      = chk_q + mem_data_q;
            word_cnt_d = word_cnt_inc_s;
            byte_cnt_d = 2'd0;
            word_d     = 32'h0000_0000;
            if (word_cnt_inc_s == len_q) begin
               state_d      = DONE;
               byte_ready_d = 1'b0;
               busy_d       = 1'b0;
               done_d       = 1'b1;
               cpu_hold_d   = 1'b0;
            end else begin
               state_d      = RECV;
               byte_ready_d = 1'b1;
            end
         end

         default: begin
            state_d      = IDLE;
            byte_ready_d = 1'b0;
            busy_d       = 1'b0;
            done_d       = 1'b0;
            cpu_hold_d   = 1'b1;
         end
      endcase
   end

   // State and registered outputs; reset discards any partial word.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         len_q        <= CNT_ZERO;
         word_cnt_q   <= CNT_ZERO;
         byte_cnt_q   <= 2'd0;
         word_q       <= 32'h0000_0000;
         byte_ready_q <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= 32'h0000_0000;
         mem_data_q   <= 32'h0000_0000;
         cpu_hold_q   <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         chk_q        <= 32'h0000_0000;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         word_cnt_q   <= word_cnt_d;
         byte_cnt_q   <= byte_cnt_d;
         word_q       <= word_d;
         byte_ready_q <= byte_ready_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_data_q   <= mem_data_d;
         cpu_hold_q   <= cpu_hold_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         err_q        <= err_d;
         chk_q        <= chk_d;
      end
   end

   assign byte_ready_o = byte_ready_q;
   assign mem_we_o     = mem_we_q;
   assign mem_addr_o   = mem_addr_q;
   assign mem_data_o   = mem_data_q;
   assign cpu_hold_o   = cpu_hold_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign err_o        = err_q;
   assign chk_o        = chk_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// ---------------------------------------------------------------------------
// tb_instr_mem_loader
//   Directed bench: a per-cycle vector table for the basic load and the
//   illegal-length cases, then hand-written sequences for stalled input,
//   reset mid-load, and a full-capacity load followed by a reload.
// ---------------------------------------------------------------------------
module tb_instr_mem_loader;

   logic        clk_i;
   logic        rst_i;
   logic        start_i;
   logic [5:0]  len_i;
   logic        byte_valid_i;
   logic [7:0]  byte_data_i;
   logic        byte_ready_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_data_o;
   logic        cpu_hold_o;
   logic        busy_o;
   logic        done_o;
   logic        err_o;
   logic [31:0] chk_o;

   instr_mem_loader dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .start_i      (start_i),
      .len_i        (len_i),
      .byte_valid_i (byte_valid_i),
      .byte_data_i  (byte_data_i),
      .byte_ready_o (byte_ready_o),
      .mem_we_o     (mem_we_o),
      .mem_addr_o   (mem_addr_o),
      .mem_data_o   (mem_data_o),
      .cpu_hold_o   (cpu_hold_o),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .err_o        (err_o),
      .chk_o        (chk_o)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   int n_vec  = 0;
   int n_miss = 0;
   int cyc    = 0;

   // Cycle counter used for the throughput bound.
   always @(posedge clk_i) cyc <= cyc + 1;

   typedef struct {
      logic        start;
      logic [5:0]  len;
      logic        valid;
      logic [7:0]  data;
      logic        rdy;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdat;
      logic        hold;
      logic        busy;
      logic        done;
      logic        err;
      logic [31:0] chk;
   } vec_t;

   function automatic vec_t mkv(input logic s, input logic [5:0] l, input logic v,
                                input logic [7:0] d, input logic rdy, input logic we,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic h, input logic b, input logic dn,
                                input logic e, input logic [31:0] c);
      vec_t r;
      r.start = s;   r.len  = l;  r.valid = v;  r.data = d;
      r.rdy   = rdy; r.we   = we; r.addr  = a;  r.wdat = wd;
      r.hold  = h;   r.busy = b;  r.done  = dn; r.err  = e;  r.chk = c;
      return r;
   endfunction

   // Write monitor: record every strobe and check it is a lone one-cycle
   // pulse with byte_ready low and busy high.
   logic [31:0] wr_a[$];
   logic [31:0] wr_d[$];
   logic [31:0] exp_a[$];
   logic [31:0] exp_d[$];
   logic        prev_we = 1'b0;

   always @(negedge clk_i) begin
      if (mem_we_o === 1'b1) begin
         wr_a.push_back(mem_addr_o);
         wr_d.push_back(mem_data_o);
         n_vec = n_vec + 1;
         if (prev_we || byte_ready_o || !busy_o) begin
            n_miss = n_miss + 1;
            $display("FAIL we_pulse: got prev_we=%b ready=%b busy=%b, expected 0 0 1",
                     prev_we, byte_ready_o, busy_o);
         end
      end
      prev_we <= mem_we_o;
   end

   task automatic check_out(input string name, input vec_t e);
      logic [101:0] act;
      logic [101:0] exp;
      act = {byte_ready_o, mem_we_o, mem_addr_o, mem_data_o, cpu_hold_o,
             busy_o, done_o, err_o, chk_o};
      exp = {e.rdy, e.we, e.addr, e.wdat, e.hold, e.busy, e.done, e.err, e.chk};
      n_vec = n_vec + 1;
      if (act !== exp) begin
         n_miss = n_miss + 1;
         $display("FAIL %s: got rdy=%b we=%b addr=%h data=%h hold=%b busy=%b done=%b err=%b chk=%h; expected rdy=%b we=%b addr=%h data=%h hold=%b busy=%b done=%b err=%b chk=%h",
                  name, byte_ready_o, mem_we_o, mem_addr_o, mem_data_o, cpu_hold_o,
                  busy_o, done_o, err_o, chk_o, e.rdy, e.we, e.addr, e.wdat,
                  e.hold, e.busy, e.done, e.err, e.chk);
      end
   endtask

   task automatic check_val(input string name, input logic [31:0] act,
                            input logic [31:0] exp);
      n_vec = n_vec + 1;
      if (act !== exp) begin
         n_miss = n_miss + 1;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Offer one byte after an optional idle gap; wait until it is taken.
   task automatic send_byte(input logic [7:0] b, input int max_gap);
      int   gap;
      logic rdy;
      bit   taken;
      gap   = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      taken = 1'b0;
      for (int g = 0; g < gap; g++) begin
         byte_valid_i = 1'b0;
         @(posedge clk_i); #1;
      end
      byte_valid_i = 1'b1;
      byte_data_i  = b;
      for (int t = 0; t < 20 && !taken; t++) begin
         rdy = byte_ready_o;
         @(posedge clk_i); #1;
         if (rdy) begin
            taken = 1'b1;
         end
      end
      byte_valid_i = 1'b0;
      if (!taken) begin
         n_vec  = n_vec + 1;
         n_miss = n_miss + 1;
         $display("FAIL byte_accept: got no ready within 20 cycles, expected acceptance of %h", b);
      end
   endtask

   // Send a word MSB first; the write strobe must be up right after byte 3.
   task automatic send_word(input logic [31:0] w, input logic [31:0] a, input int max_gap);
      for (int k = 0; k < 4; k++) begin
         send_byte(w[31-8*k -: 8], max_gap);
      end
      check_val("we_latency", {mem_we_o, mem_addr_o[30:0]}, {1'b1, a[30:0]});
      check_val("we_data", mem_data_o, w);
   endtask

   task automatic wait_done(input int max_cyc);
      bit seen;
      seen = 1'b0;
      for (int t = 0; t < max_cyc && !seen; t++) begin
         if (done_o === 1'b1) begin
            seen = 1'b1;
         end else begin
            @(posedge clk_i); #1;
         end
      end
      check_val("wait_done", {31'd0, seen}, 32'd1);
   endtask

   task automatic pulse_start(input logic [5:0] l);
      start_i = 1'b1;
      len_i   = l;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      len_i   = 6'd0;
   endtask

   task automatic check_writes(input string name);
      check_val({name, "_count"}, wr_a.size(), exp_a.size());
      for (int i = 0; i < exp_a.size() && i < wr_a.size(); i++) begin
         check_val({name, "_addr"}, wr_a[i], exp_a[i]);
         check_val({name, "_data"}, wr_d[i], exp_d[i]);
      end
   endtask

   task automatic clear_writes();
      wr_a.delete(); wr_d.delete(); exp_a.delete(); exp_d.delete();
   endtask

   // Watchdog: the run is a few thousand time units; never hang.
   initial begin
      #100000;
      $display("FAIL watchdog: got no finish by time 100000, expected earlier finish");
      $fatal(1, "watchdog expired");
   end

   localparam logic [31:0] W0 = 32'h8C01_0004;
   localparam logic [31:0] W1 = 32'h2002_0005;
   localparam logic [31:0] C2 = 32'hAC03_0009;
   localparam logic [31:0] WD = 32'hDEAD_BEEF;

   vec_t        vecs[$];
   vec_t        rst_exp;
   logic [31:0] chk_m;
   logic [31:0] w;
   logic [7:0]  wb;
   int          c0;

   initial begin
      rst_i = 1'b0; start_i = 1'b0; len_i = 6'd0;
      byte_valid_i = 1'b0; byte_data_i = 8'h00;
      rst_exp = mkv(1'b0, 6'd0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 32'h0,
                    1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

      // Asynchronous reset between clock edges takes effect at once.
      #2 rst_i = 1'b1;
      #1 check_out("reset_async", rst_exp);
      @(posedge clk_i); @(posedge clk_i); #1;
      rst_i = 1'b0;
      @(posedge clk_i); #1;
      check_out("reset_idle", rst_exp);

      //                start len  vld  data    rdy   we    addr   wdata hold  busy  done  err   chk
      vecs.push_back(mkv(1'b1, 6'd2, 1'b0, 8'h00, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0));
      vecs.push_back(mkv(1'b0, 6'd0, 1'b1, 8'h8C, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0));
      vecs.push_back(mkv(1'b0, 6'd0, 1'b1, 8'h01, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0));
      vecs.push_back(mkv(1'b0, 6'd0, 1'b1, 8'h00, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0));
      vecs.push_back(mkv(1'b0, 6'd0, 1'b1, 8'h04, 1'b0, 1'b1, 32'h0, W0,    1'b1, 1'b1, 1'b0, 1'b0, 32'h0));
      // start ignored in WRITE; byte offered during WRITE is not consumed
      vecs.push_back(mkv(1'b1, 6'd5, 1'b1, 8'h20, 1'b1, 1'b0, 32'h0, W0,    1'b1, 1'b1, 1'b0, 1'b0, W0));
      // start ignored in RECV; byte 20 taken now
      vecs.push_back(mkv(1'b1, 6'd1, 1'b1, 8'h20, 1'b1, 1'b0, 32'h0, W0,    1'b1, 1'b1, 1'b0, 1'b0, W0));
      vecs.push_back(mkv(1'b0, 6'd0, 1'b1, 8'h02, 1'b1, 1'b0, 32'h0, W0,    1'b1, 1'b1, 1'b0, 1'b0, W0));
      vecs.push_back(mkv(1'b0, 6'd0, 1'b1, 8'h00, 1'b1, 1'b0, 32'h0, W0,    1'b1, 1'b1, 1'b0, 1'b0, W0));
      vecs.push_back(mkv(1'b0, 6'd0, 1'b1, 8'h05, 1'b0, 1'b1, 32'h4, W1,    1'b1, 1'b1, 1'b0, 1'b0, W0));
      vecs.push_back(mkv(1'b0, 6'd0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h4, W1,    1'b0, 1'b0, 1'b1, 1'b0, C2));
      // byte offered in DONE is ignored
      vecs.push_back(mkv(1'b0, 6'd0, 1'b1, 8'h55, 1'b0, 1'b0, 32'h4, W1,    1'b0, 1'b0, 1'b1, 1'b0, C2));
      // len 0 from DONE: error, back to IDLE, CPU held again
      vecs.push_back(mkv(1'b1, 6'd0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h4, W1,    1'b1, 1'b0, 1'b0, 1'b1, C2));
      // len 33 from IDLE: error, stays in IDLE
      vecs.push_back(mkv(1'b1, 6'd33,1'b0, 8'h00, 1'b0, 1'b0, 32'h4, W1,    1'b1, 1'b0, 1'b0, 1'b1, C2));
      vecs.push_back(mkv(1'b0, 6'd0, 1'b1, 8'h77, 1'b0, 1'b0, 32'h4, W1,    1'b1, 1'b0, 1'b0, 1'b1, C2));
      // legal start clears err and chk
      vecs.push_back(mkv(1'b1, 6'd1, 1'b0, 8'h00, 1'b1, 1'b0, 32'h4, W1,    1'b1, 1'b1, 1'b0, 1'b0, 32'h0));
      vecs.push_back(mkv(1'b0, 6'd0, 1'b1, 8'hDE, 1'b1, 1'b0, 32'h4, W1,    1'b1, 1'b1, 1'b0, 1'b0, 32'h0));
      vecs.push_back(mkv(1'b0, 6'd0, 1'b1, 8'hAD, 1'b1, 1'b0, 32'h4, W1,    1'b1, 1'b1, 1'b0, 1'b0, 32'h0));
      vecs.push_back(mkv(1'b0, 6'd0, 1'b1, 8'hBE, 1'b1, 1'b0, 32'h4, W1,    1'b1, 1'b1, 1'b0, 1'b0, 32'h0));
      vecs.push_back(mkv(1'b0, 6'd0, 1'b1, 8'hEF, 1'b0, 1'b1, 32'h0, WD,    1'b1, 1'b1, 1'b0, 1'b0, 32'h0));
      vecs.push_back(mkv(1'b0, 6'd0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0, WD,    1'b0, 1'b0, 1'b1, 1'b0, WD));
      // len 63 from DONE: error, IDLE, hold
      vecs.push_back(mkv(1'b1, 6'd63,1'b0, 8'h00, 1'b0, 1'b0, 32'h0, WD,    1'b1, 1'b0, 1'b0, 1'b1, WD));

      for (int i = 0; i < vecs.size(); i++) begin
         start_i      = vecs[i].start;
         len_i        = vecs[i].len;
         byte_valid_i = vecs[i].valid;
         byte_data_i  = vecs[i].data;
         @(posedge clk_i); #1;
         check_out($sformatf("vec%0d", i), vecs[i]);
      end
      start_i = 1'b0; len_i = 6'd0; byte_valid_i = 1'b0;

      // Same two-word program with random idle cycles on the byte stream.
      clear_writes();
      exp_a.push_back(32'h0); exp_d.push_back(W0);
      exp_a.push_back(32'h4); exp_d.push_back(W1);
      pulse_start(6'd2);
      send_word(W0, 32'h0, 2);
      send_word(W1, 32'h4, 2);
      wait_done(20);
      check_val("gap_chk", chk_o, C2);
      check_val("gap_hold", {30'd0, cpu_hold_o, err_o}, 32'd0);
      check_writes("gap_wr");

      // Reset after two bytes: partial word is discarded.
      clear_writes();
      pulse_start(6'd1);
      send_byte(8'h8C, 0);
      send_byte(8'h01, 0);
      check_val("midload_busy", {31'd0, busy_o}, 32'd1);
      #2 rst_i = 1'b1;
      #1 check_out("reset_midload", rst_exp);
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      @(posedge clk_i); #1;
      exp_a.push_back(32'h0); exp_d.push_back(WD);
      pulse_start(6'd1);
      send_word(WD, 32'h0, 0);
      wait_done(20);
      check_writes("after_rst_wr");

      // Full-capacity load, back to back.
      clear_writes();
      chk_m = 32'h0;
      pulse_start(6'd32);
      c0 = cyc - 1;
      for (int i = 0; i < 32; i++) begin
         wb = 8'(i);
         w  = {wb, 8'hA5, 8'(i * 3), 8'h3C};
         exp_a.push_back(32'(i * 4));
         exp_d.push_back(w);
         chk_m = chk_m + w;
         send_word(w, 32'(i * 4), 0);
      end
      wait_done(20);
      check_val("full_throughput", {31'd0, (cyc - c0) <= 161}, 32'd1);
      check_val("full_chk", chk_o, chk_m);
      check_val("full_done", {29'd0, done_o, cpu_hold_o, busy_o}, 32'd4);
      check_writes("full_wr");

      // Restart from DONE reloads at address 0.
      clear_writes();
      exp_a.push_back(32'h0); exp_d.push_back(32'h1234_5678);
      pulse_start(6'd1);
      check_val("reload_flags", {29'd0, done_o, cpu_hold_o, busy_o}, 32'd3);
      send_word(32'h1234_5678, 32'h0, 1);
      wait_done(20);
      check_val("reload_chk", chk_o, 32'h1234_5678);
      check_writes("reload_wr");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
